boot_memory_arbiter: RTL and testbench
======================================

// Module: boot_memory_arbiter
// PURPOSE
//  Shares the single-port boot memory between two requesters: port A (CPU fetch/data) and port B (boot loader / DMA).
//  Issues at most one access per cycle and arbitrates round-robin, with an optional bounded burst lock on port B.
//  Drives the memory's ADDRESS/DATA_IN/WR and routes its 1-cycle-latency read data back to the issuing requester.
//  Sits directly between the requesters and the boot memory instance.
// PARAMETERS
//  BITS          16  data width
//  ADDRESS_BITS  16  word address width
//  MAX_BURST     8   max consecutive grants to B while B_LOCK held (1..255)
// PORTS
//  CLK           in   1             system clock, all state on rising edge
//  RST           in   1             synchronous reset, active-high
//  A_REQ         in   1             A requests an access this cycle
//  A_WR          in   1             1=write, 0=read
//  A_ADDRESS     in   ADDRESS_BITS  A word address
//  A_DATA_IN     in   BITS          A write data
//  A_GNT         out  1             A access issued this cycle (combinational)
//  A_RVALID      out  1             A read data valid (registered)
//  A_DATA_OUT    out  BITS          A read data
//  B_REQ/B_WR/B_ADDRESS/B_DATA_IN   as for A, port B
//  B_LOCK        in   1             B requests burst ownership
//  B_GNT/B_RVALID/B_DATA_OUT        as for A, port B
//  MEM_ADDRESS   out  ADDRESS_BITS  to memory ADDRESS
//  MEM_DATA_IN   out  BITS          to memory DATA_IN
//  MEM_WR        out  1             to memory WR
//  MEM_DATA_OUT  in   BITS          from memory DATA_OUT (valid 1 cycle after address)
// BEHAVIOUR
//  - Reset: A_GNT=B_GNT=0, MEM_WR=0, A_RVALID=B_RVALID=0, priority pointer=A, state=IDLE, burst count=0.
//    GNT/MEM_WR gated low while RST=1; a read issued in the cycle RST asserts produces no RVALID.
//  - Grant is combinational: REQ and GNT high in the same cycle = access issued.
//    A requester holds REQ/WR/ADDRESS/DATA_IN stable until GNT.
//  - Exactly one of A_GNT/B_GNT when any REQ is high; none when both low.
//    MEM_ADDRESS/MEM_DATA_IN mux from the winner (A when idle); MEM_WR = winner's WR & GNT.
//  - States: IDLE (round-robin) and BURST_B.
//  - IDLE: if one REQ, grant it. If both, grant the port named by the pointer;
//    after any grant the pointer moves to the other port.
//    If B is granted with B_LOCK=1, go to BURST_B, count=1.
//  - BURST_B: B granted whenever B_REQ, A stalled.
//    Count increments per B grant. Return to IDLE with pointer=A when:
//    B_LOCK=0, or count reaches MAX_BURST, or B_REQ=0 for a cycle (idle cycle may grant A if A_REQ).
//    Count saturates, no wrap.
//  - Read return: reads issued in cycle N give xRVALID=1 in N+1 for one cycle, xDATA_OUT=MEM_DATA_OUT.
//    A write produces no RVALID. Back-to-back reads give a RVALID every cycle. DATA_OUT holds last value when RVALID=0.
//  - Read-after-write same address in consecutive cycles returns the new data (memory is write-first on the following cycle).
//  - Simultaneous A write and B read same address: only one issued per cycle; order follows arbitration.
// TESTING
//  1. Reset with A_REQ=B_REQ=1 -> no GNT, MEM_WR=0, no RVALID. First cycle after reset: A_GNT=1.
//  2. A and B both read continuously -> GNT alternates A,B,A,B; each RVALID one cycle after its GNT, data matches the preloaded ROM words.
//  3. B_LOCK=1, B_REQ=1, A_REQ=1, MAX_BURST=8 -> 8 consecutive B_GNT, then A_GNT, then B resumes.
//  4. B writes 16'hBEEF to 0x0010, A reads 0x0010 next cycle -> A_DATA_OUT=16'hBEEF with A_RVALID.
//  5. RST asserted the cycle after A read issued -> A_RVALID stays 0, pointer=A after reset.
//  6. B_LOCK dropped mid-burst after 3 grants -> IDLE, next contended grant goes to A.

Source files
------------

// File: rtl/boot_memory_arbiter.sv
// rtl/boot_memory_arbiter.sv - single-port boot memory arbiter, round-robin A/B with bounded B burst lock
// Grants are combinational; read data returns one cycle after issue to the requester that won.
module boot_memory_arbiter #(
   parameter int BITS         = 16,
   parameter int ADDRESS_BITS = 16,
   parameter int MAX_BURST    = 8
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    A_REQ,
   input  logic                    A_WR,
   input  logic [ADDRESS_BITS-1:0] A_ADDRESS,
   input  logic [BITS-1:0]         A_DATA_IN,
   output logic                    A_GNT,
   output logic                    A_RVALID,
   output logic [BITS-1:0]         A_DATA_OUT,
   input  logic                    B_REQ,
   input  logic                    B_WR,
   input  logic [ADDRESS_BITS-1:0] B_ADDRESS,
   input  logic [BITS-1:0]         B_DATA_IN,
   input  logic                    B_LOCK,
   output logic                    B_GNT,
   output logic                    B_RVALID,
   output logic [BITS-1:0]         B_DATA_OUT,
   output logic [ADDRESS_BITS-1:0] MEM_ADDRESS,
   output logic [BITS-1:0]         MEM_DATA_IN,
   output logic                    MEM_WR,
   input  logic [BITS-1:0]         MEM_DATA_OUT
);

   typedef enum logic {IDLE, BURST_B} state_t;

   localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);
   localparam logic       BURST_EN    = (MAX_BURST > 1);

   state_t          state_q, state_d;
   logic            ptr_q, ptr_d;
   logic [7:0]      count_q, count_d;
   logic            a_rvalid_q, b_rvalid_q;
   logic [BITS-1:0] a_data_q, b_data_q;
   logic            a_gnt, b_gnt;
   logic            burst_hold;
   logic            eff_ptr;

   // ptr: 0 = A next, 1 = B next. Any cycle in BURST_B that B does not hold
   // is arbitrated as an IDLE cycle with A preferred, which also ends the burst.
   always_comb begin
      a_gnt      = 1'b0;
      b_gnt      = 1'b0;
      state_d    = state_q;
      ptr_d      = ptr_q;
      count_d    = count_q;
      burst_hold = (state_q == BURST_B) && B_REQ && B_LOCK;
      eff_ptr    = (state_q == BURST_B) ? 1'b0 : ptr_q;
      if (RST) begin
         state_d = IDLE;
      end else if (burst_hold) begin
         b_gnt   = 1'b1;
         count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
         if (count_d >= MAX_BURST_C) begin
            state_d = IDLE;
            ptr_d   = 1'b0;
            count_d = 8'd0;
         end
      end else begin
         state_d = IDLE;
         count_d = 8'd0;
         ptr_d   = eff_ptr;
         if (A_REQ && B_REQ) begin
            a_gnt = ~eff_ptr;
            b_gnt = eff_ptr;
         end else begin
            a_gnt = A_REQ;
            b_gnt = B_REQ;
         end
         if (a_gnt) begin
            ptr_d = 1'b1;
         end
         if (b_gnt) begin
            ptr_d = 1'b0;
            if (B_LOCK && BURST_EN) begin
               state_d = BURST_B;
               count_d = 8'd1;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         ptr_q      <= 1'b0;
         count_q    <= 8'd0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         a_data_q   <= '0;
         b_data_q   <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         count_q    <= count_d;
         a_rvalid_q <= a_gnt & ~A_WR;
         b_rvalid_q <= b_gnt & ~B_WR;
         if (a_rvalid_q) begin
            a_data_q <= MEM_DATA_OUT;
         end
         if (b_rvalid_q) begin
            b_data_q <= MEM_DATA_OUT;
         end
      end
   end

   assign A_GNT       = a_gnt;
   assign B_GNT       = b_gnt;
   assign MEM_ADDRESS = b_gnt ? B_ADDRESS : A_ADDRESS;
   assign MEM_DATA_IN = b_gnt ? B_DATA_IN : A_DATA_IN;
   assign MEM_WR      = (a_gnt & A_WR) | (b_gnt & B_WR);

   // Returning data is suppressed in the cycle reset asserts.
   assign A_RVALID   = a_rvalid_q & ~RST;
   assign B_RVALID   = b_rvalid_q & ~RST;
   assign A_DATA_OUT = a_rvalid_q ? MEM_DATA_OUT : a_data_q;
   assign B_DATA_OUT = b_rvalid_q ? MEM_DATA_OUT : b_data_q;

endmodule

// File: tb/tb_boot_memory_arbiter.sv
// tb/tb_boot_memory_arbiter.sv - scoreboard bench for boot_memory_arbiter
// Directed per-cycle vectors push expected grants/read data; a negedge monitor pops and compares.
module tb_boot_memory_arbiter;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        A_REQ = 1'b0, A_WR = 1'b0, A_GNT, A_RVALID;
   logic [15:0] A_ADDRESS = '0, A_DATA_IN = '0, A_DATA_OUT;
   logic        B_REQ = 1'b0, B_WR = 1'b0, B_LOCK = 1'b0, B_GNT, B_RVALID;
   logic [15:0] B_ADDRESS = '0, B_DATA_IN = '0, B_DATA_OUT;
   logic [15:0] MEM_ADDRESS, MEM_DATA_IN, MEM_DATA_OUT;
   logic        MEM_WR;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct packed {
      logic a_gnt;
      logic b_gnt;
      logic wr;
      logic a_rv;
      logic b_rv;
   } vec_t;

   vec_t        exp_q[$];
   logic [15:0] a_dq[$];
   logic [15:0] b_dq[$];
   logic [15:0] wmem[int];

   always #5 CLK = ~CLK;

   boot_memory_arbiter #(.BITS(16), .ADDRESS_BITS(16), .MAX_BURST(8)) dut (
      .CLK(CLK), .RST(RST),
      .A_REQ(A_REQ), .A_WR(A_WR), .A_ADDRESS(A_ADDRESS), .A_DATA_IN(A_DATA_IN),
      .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_DATA_OUT(A_DATA_OUT),
      .B_REQ(B_REQ), .B_WR(B_WR), .B_ADDRESS(B_ADDRESS), .B_DATA_IN(B_DATA_IN),
      .B_LOCK(B_LOCK), .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_DATA_OUT(B_DATA_OUT),
      .MEM_ADDRESS(MEM_ADDRESS), .MEM_DATA_IN(MEM_DATA_IN), .MEM_WR(MEM_WR),
      .MEM_DATA_OUT(MEM_DATA_OUT)
   );

   function automatic logic [15:0] rom(input logic [15:0] a);
      return 16'h1000 + a * 16'h0011;
   endfunction

   // Boot memory: preloaded ROM image overlaid with written words, write-first, 1-cycle read.
   always @(posedge CLK) begin
      if (MEM_WR) begin
         wmem[int'(MEM_ADDRESS)] = MEM_DATA_IN;
         MEM_DATA_OUT <= MEM_DATA_IN;
      end else begin
         MEM_DATA_OUT <= wmem.exists(int'(MEM_ADDRESS)) ? wmem[int'(MEM_ADDRESS)] : rom(MEM_ADDRESS);
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // e = {a_gnt, b_gnt, mem_wr, a_rvalid, b_rvalid}; adx/bdx = read data expected with RVALID this cycle
   task automatic step(input logic rst,
                       input logic ar, input logic aw, input logic [15:0] aa, input logic [15:0] ad,
                       input logic br, input logic bw, input logic [15:0] ba, input logic [15:0] bd,
                       input logic bl, input logic [4:0] e,
                       input logic [15:0] adx, input logic [15:0] bdx);
      @(posedge CLK);
      #1;
      RST = rst;
      A_REQ = ar; A_WR = aw; A_ADDRESS = aa; A_DATA_IN = ad;
      B_REQ = br; B_WR = bw; B_ADDRESS = ba; B_DATA_IN = bd; B_LOCK = bl;
      exp_q.push_back(vec_t'(e));
      if (e[1]) a_dq.push_back(adx);
      if (e[0]) b_dq.push_back(bdx);
   endtask

   initial begin : monitor
      vec_t v;
      forever begin
         @(negedge CLK);
         cyc++;
         if (exp_q.size() > 0) begin
            v = exp_q.pop_front();
            chk("a_gnt", {15'd0, A_GNT}, {15'd0, v.a_gnt});
            chk("b_gnt", {15'd0, B_GNT}, {15'd0, v.b_gnt});
            chk("mem_wr", {15'd0, MEM_WR}, {15'd0, v.wr});
            chk("a_rvalid", {15'd0, A_RVALID}, {15'd0, v.a_rv});
            chk("b_rvalid", {15'd0, B_RVALID}, {15'd0, v.b_rv});
         end
         if (A_RVALID) begin
            if (a_dq.size() > 0) chk("a_data_out", A_DATA_OUT, a_dq.pop_front());
            else chk("a_rvalid_unexpected", 16'd1, 16'd0);
         end
         if (B_RVALID) begin
            if (b_dq.size() > 0) chk("b_data_out", B_DATA_OUT, b_dq.pop_front());
            else chk("b_rvalid_unexpected", 16'd1, 16'd0);
         end
      end
   end

   initial begin
      // reset with both requesting, then alternating reads
      step(1, 1,0,16'h01,0, 1,0,16'h02,0, 0, 5'b00000, 0, 0);
      step(1, 1,0,16'h01,0, 1,0,16'h02,0, 0, 5'b00000, 0, 0);
      step(0, 1,0,16'h01,0, 1,0,16'h02,0, 0, 5'b10000, 0, 0);
      step(0, 1,0,16'h03,0, 1,0,16'h02,0, 0, 5'b01010, rom(16'h01), 0);
      step(0, 1,0,16'h03,0, 1,0,16'h04,0, 0, 5'b10001, 0, rom(16'h02));
      step(0, 1,0,16'h05,0, 1,0,16'h04,0, 0, 5'b01010, rom(16'h03), 0);
      step(0, 1,0,16'h05,0, 1,0,16'h06,0, 0, 5'b10001, 0, rom(16'h04));
      step(0, 0,0,16'h00,0, 0,0,16'h00,0, 0, 5'b00010, rom(16'h05), 0);
      // B writes BEEF, A reads it back next cycle
      step(0, 0,0,16'h00,0, 1,1,16'h10,16'hBEEF, 0, 5'b01100, 0, 0);
      step(0, 1,0,16'h10,0, 0,0,16'h00,0, 0, 5'b10000, 0, 0);
      step(0, 0,0,16'h00,0, 0,0,16'h00,0, 0, 5'b00010, 16'hBEEF, 0);
      // B burst lock: 8 B grants, then A, then B resumes
      step(0, 1,0,16'h07,0, 1,0,16'h20,0, 1, 5'b01000, 0, 0);
      for (int i = 1; i < 8; i++)
         step(0, 1,0,16'h07,0, 1,0,16'h20 + 16'(i),0, 1, 5'b01001, 0, rom(16'h20 + 16'(i - 1)));
      step(0, 1,0,16'h07,0, 1,0,16'h28,0, 1, 5'b10001, 0, rom(16'h27));
      step(0, 0,0,16'h00,0, 1,0,16'h28,0, 1, 5'b01010, rom(16'h07), 0);
      step(0, 0,0,16'h00,0, 0,0,16'h00,0, 0, 5'b00001, 0, rom(16'h28));
      // lock dropped after 3 burst grants: contended grant goes to A
      step(0, 0,0,16'h00,0, 1,0,16'h30,0, 1, 5'b01000, 0, 0);
      step(0, 1,0,16'h09,0, 1,0,16'h31,0, 1, 5'b01001, 0, rom(16'h30));
      step(0, 1,0,16'h09,0, 1,0,16'h32,0, 1, 5'b01001, 0, rom(16'h31));
      step(0, 1,0,16'h09,0, 1,0,16'h33,0, 0, 5'b10001, 0, rom(16'h32));
      step(0, 0,0,16'h00,0, 1,0,16'h33,0, 0, 5'b01010, rom(16'h09), 0);
      step(0, 0,0,16'h00,0, 0,0,16'h00,0, 0, 5'b00001, 0, rom(16'h33));
      // reset the cycle after an A read: no RVALID, pointer back at A
      step(0, 1,0,16'h0B,0, 1,0,16'h0C,0, 0, 5'b10000, 0, 0);
      step(1, 1,0,16'h0D,0, 1,0,16'h0C,0, 0, 5'b00000, 0, 0);
      step(0, 1,0,16'h0D,0, 1,0,16'h0C,0, 0, 5'b10000, 0, 0);
      step(0, 0,0,16'h00,0, 1,0,16'h0C,0, 0, 5'b01010, rom(16'h0D), 0);
      step(0, 0,0,16'h00,0, 0,0,16'h00,0, 0, 5'b00001, 0, rom(16'h0C));
      // A write then B read; then A write vs B read same address, arbitration order
      step(0, 1,1,16'h40,16'h1234, 0,0,16'h00,0, 0, 5'b10100, 0, 0);
      step(0, 0,0,16'h00,0, 1,0,16'h40,0, 0, 5'b01000, 0, 0);
      step(0, 0,0,16'h00,0, 0,0,16'h00,0, 0, 5'b00001, 0, 16'h1234);
      step(0, 1,1,16'h41,16'h5555, 1,0,16'h41,0, 0, 5'b10100, 0, 0);
      step(0, 0,0,16'h00,0, 1,0,16'h41,0, 0, 5'b01000, 0, 0);
      step(0, 0,0,16'h00,0, 0,0,16'h00,0, 0, 5'b00001, 0, 16'h5555);
      step(0, 0,0,16'h00,0, 0,0,16'h00,0, 0, 5'b00000, 0, 0);
      repeat (3) @(posedge CLK);
      #1;
      chk("vec_queue_drained", 16'(exp_q.size()), 16'd0);
      chk("a_data_queue_drained", 16'(a_dq.size()), 16'd0);
      chk("b_data_queue_drained", 16'(b_dq.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
